// File: rtl/sensor_pkg.sv
// Shared types and default 65 MHz timing for the Pong ultrasonic sensor scheduler.
package sensor_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    GAP       = 3'd4
  } sched_state_t;

  localparam int DEF_CYC_PER_TRIG = 650;
  localparam int DEF_CYC_PER_CM   = 3770;
  localparam int DEF_CYC_TIMEOUT  = 1_950_000;
  localparam int DEF_CYC_GAP      = 650_000;

  localparam logic [7:0] DIST_MAX = 8'd255;

  // Rounded mean of two distances, computed 9 bits wide so the carry is kept.
  function automatic logic [7:0] dist_avg(input logic [7:0] prev, input logic [7:0] cur);
    logic [8:0] sum;
    sum = {1'b0, prev} + {1'b0, cur} + 9'd1;
    return sum[8:1];
  endfunction

endpackage

// File: rtl/sensor_scheduler_echo_timer.sv
// Echo pulse timer shared by both sensors: edge detect, cm counter and timeout.
module echo_timer
  import sensor_pkg::*;
#(
  parameter int CYC_PER_CM  = DEF_CYC_PER_CM,
  parameter int CYC_TIMEOUT = DEF_CYC_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       echo_sync,
  output logic       rise,
  output logic [7:0] cm,
  output logic       done,
  output logic       timed_out
);

  localparam int SUB_W = $clog2(CYC_PER_CM + 1);
  localparam int TO_W  = $clog2(CYC_TIMEOUT + 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYC_PER_CM - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(CYC_TIMEOUT - 1);

  logic             busy_r, meas_r, echo_prev_r;
  logic [SUB_W-1:0] sub_r, sub_nxt_s;
  logic [7:0]       cm_r, cm_nxt_s;
  logic [TO_W-1:0]  tcnt_r;
  logic             wrap_s, tc_s;

  // Edge/terminal decode; cm includes this cycle's wrap so a fall on a wrap still counts it.
  always_comb begin
    rise      = busy_r & ~meas_r & echo_sync & ~echo_prev_r;
    done      = busy_r & meas_r & ~echo_sync & echo_prev_r;
    tc_s      = busy_r & (tcnt_r == TO_LAST);
    timed_out = tc_s & ~rise & ~done;
    wrap_s    = meas_r & (sub_r == SUB_LAST);
    if (!meas_r) begin
      sub_nxt_s = sub_r;
    end else if (wrap_s) begin
      sub_nxt_s = {SUB_W{1'b0}};
    end else begin
      sub_nxt_s = sub_r + SUB_W'(1'b1);
    end
    if (wrap_s && (cm_r != DIST_MAX)) begin
      cm_nxt_s = cm_r + 8'd1;
    end else begin
      cm_nxt_s = cm_r;
    end
    cm = cm_nxt_s;
  end

  // Counters restart on start (WAIT_RISE entry) and again on the echo rise (MEASURE entry).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r      <= 1'b0;
      meas_r      <= 1'b0;
      echo_prev_r <= 1'b0;
      sub_r       <= {SUB_W{1'b0}};
      cm_r        <= 8'd0;
      tcnt_r      <= {TO_W{1'b0}};
    end else begin
      echo_prev_r <= echo_sync;
      if (start) begin
        busy_r <= 1'b1;
        meas_r <= 1'b0;
        sub_r  <= {SUB_W{1'b0}};
        cm_r   <= 8'd0;
        tcnt_r <= {TO_W{1'b0}};
      end else if (done || timed_out) begin
        busy_r <= 1'b0;
        meas_r <= 1'b0;
      end else if (rise) begin
        meas_r <= 1'b1;
        sub_r  <= {SUB_W{1'b0}};
        cm_r   <= 8'd0;
        tcnt_r <= {TO_W{1'b0}};
      end else if (busy_r) begin
        sub_r  <= sub_nxt_s;
        cm_r   <= cm_nxt_s;
        tcnt_r <= tcnt_r + TO_W'(1'b1);
      end
    end
  end

endmodule

// File: rtl/sensor_scheduler.sv
// Alternating trigger/echo scheduler for the left/right paddle ultrasonic sensors.
// Optional feature macro: SENSOR_SCHED_FILTER_EN (averages each good reading with the previous one).
module sensor_scheduler
  import sensor_pkg::*;
#(
  parameter int CYC_PER_TRIG = DEF_CYC_PER_TRIG,
  parameter int CYC_PER_CM   = DEF_CYC_PER_CM,
  parameter int CYC_TIMEOUT  = DEF_CYC_TIMEOUT,
  parameter int CYC_GAP      = DEF_CYC_GAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] echo,
  output logic [1:0] trig,
  output logic [7:0] dist0,
  output logic [7:0] dist1,
  output logic [1:0] dist_valid,
  output logic [1:0] timeout
);

  localparam int CNT_MAX = (CYC_GAP > CYC_PER_TRIG) ? CYC_GAP : CYC_PER_TRIG;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(CYC_PER_TRIG - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CYC_GAP - 1);

  sched_state_t state_r, state_nxt_s;
  logic             sel_r, sel_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       echo_meta_r, echo_sync_r;
  logic [1:0]       trig_r, valid_r, timeout_r, sel_oh_s;
  logic [7:0]       dist0_r, dist1_r, cm_s, meas_s;
  logic             start_s, rise_s, done_s, timed_out_s;

  echo_timer #(
    .CYC_PER_CM  (CYC_PER_CM),
    .CYC_TIMEOUT (CYC_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .echo_sync (echo_sync_r[sel_r]),
    .rise      (rise_s),
    .cm        (cm_s),
    .done      (done_s),
    .timed_out (timed_out_s)
  );

  assign sel_oh_s = sel_r ? 2'b10 : 2'b01;

  // Next-state logic; sel only flips at the end of the guard gap.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) state_nxt_s = TRIG;
        else        state_nxt_s = IDLE;
      end
      TRIG: begin
        if (cnt_r == TRIG_LAST) begin
          state_nxt_s = WAIT_RISE;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = TRIG;
        end
      end
      WAIT_RISE: begin
        if (rise_s)           state_nxt_s = MEASURE;
        else if (timed_out_s) state_nxt_s = GAP;
        else                  state_nxt_s = WAIT_RISE;
      end
      MEASURE: begin
        if (done_s || timed_out_s) state_nxt_s = GAP;
        else                       state_nxt_s = MEASURE;
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          sel_nxt_s   = ~sel_r;
          state_nxt_s = enable ? TRIG : IDLE;
        end else begin
          state_nxt_s = GAP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, phase counter, echo synchronizers and the registered trigger.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      sel_r       <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      echo_meta_r <= 2'b00;
      echo_sync_r <= 2'b00;
      trig_r      <= 2'b00;
    end else begin
      echo_meta_r <= echo;
      echo_sync_r <= echo_meta_r;
      state_r     <= state_nxt_s;
      sel_r       <= sel_nxt_s;
      cnt_r       <= ((state_r == TRIG || state_r == GAP) && state_nxt_s == state_r)
                     ? cnt_r + CNT_W'(1'b1) : {CNT_W{1'b0}};
      trig_r      <= (state_nxt_s == TRIG) ? (sel_nxt_s ? 2'b10 : 2'b01) : 2'b00;
    end
  end

`ifdef SENSOR_SCHED_FILTER_EN
  logic [1:0] seen_r;

  assign meas_s = seen_r[sel_r] ? dist_avg(sel_r ? dist1_r : dist0_r, cm_s) : cm_s;

  // Tracks which sensors have produced a good reading since reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen_r <= 2'b00;
    end else if (state_r == MEASURE && done_s) begin
      seen_r <= seen_r | sel_oh_s;
    end
  end
`else
  assign meas_s = cm_s;
`endif

  // Result registers: a falling edge beats a same-cycle timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dist0_r   <= 8'd0;
      dist1_r   <= 8'd0;
      valid_r   <= 2'b00;
      timeout_r <= 2'b00;
    end else begin
      valid_r <= 2'b00;
      if (state_r == MEASURE && done_s) begin
        valid_r   <= sel_oh_s;
        timeout_r <= timeout_r & ~sel_oh_s;
        if (sel_r) dist1_r <= meas_s;
        else       dist0_r <= meas_s;
      end else if (timed_out_s) begin
        timeout_r <= timeout_r | sel_oh_s;
        if (state_r == MEASURE) begin
          if (sel_r) dist1_r <= DIST_MAX;
          else       dist0_r <= DIST_MAX;
        end
      end
    end
  end

  assign trig       = trig_r;
  assign dist0      = dist0_r;
  assign dist1      = dist1_r;
  assign dist_valid = valid_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed-random bench for sensor_scheduler against a pulse-width reference model.
`timescale 1ns/1ps
module tb_sensor_scheduler;

  localparam int P_TRIG = 10;
  localparam int P_CM   = 20;
  localparam int P_TO   = 2000;
  localparam int P_GAP  = 100;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [1:0] echo, trig, dist_valid, timeout;
  logic [7:0] dist0, dist1;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int exp_dist[2];
  bit exp_to[2];
  int exp_sel;
  int last_trig_cyc, last_strobe_cyc, rel_cyc;
`ifdef SENSOR_SCHED_FILTER_EN
  bit exp_seen[2];
`endif

  always #5 clk = ~clk;

  sensor_scheduler #(
    .CYC_PER_TRIG (P_TRIG),
    .CYC_PER_CM   (P_CM),
    .CYC_TIMEOUT  (P_TO),
    .CYC_GAP      (P_GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .echo       (echo),
    .trig       (trig),
    .dist0      (dist0),
    .dist1      (dist1),
    .dist_valid (dist_valid),
    .timeout    (timeout)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: cm = min(255, floor(W / CYC_PER_CM)), optionally averaged with the last value.
  task automatic model_good(input int s, input int w);
    int cm;
    cm = w / P_CM;
    if (cm > 255) cm = 255;
`ifdef SENSOR_SCHED_FILTER_EN
    if (exp_seen[s]) cm = (exp_dist[s] + cm + 1) / 2;
    exp_seen[s] = 1'b1;
`endif
    exp_dist[s] = cm;
    exp_to[s]   = 1'b0;
  endtask

  task automatic wait_trig();
    int n, w;
    logic [1:0] oh;
    n = 0;
    while (trig === 2'b00 && n < P_GAP + P_TO + 300) begin
      tick();
      n++;
    end
    last_trig_cyc = cyc;
    oh = (exp_sel == 1) ? 2'b10 : 2'b01;
    chk("trig_sel", trig, oh);
    w = 0;
    while (trig === oh && w < 4 * P_TRIG) begin
      tick();
      w++;
    end
    chk("trig_width", w, P_TRIG);
    chk("trig_off", trig, 2'b00);
  endtask

  // mode 0: good pulse, 1: echo never rises, 2: pulse longer than the timeout.
  task automatic serve(input int mode, input int w, input bit noise, input bit drop_en,
                       input bit chk_gap);
    int s, d, n;
    bit spurious;
    logic [1:0] oh;
    s  = exp_sel;
    oh = (s == 1) ? 2'b10 : 2'b01;
    wait_trig();
    if (chk_gap) chk("gap_len", last_trig_cyc - last_strobe_cyc, P_GAP);
    spurious = 1'b0;
    if (mode == 1) begin
      repeat (P_TO + 40) begin
        tick();
        if (dist_valid !== 2'b00) spurious = 1'b1;
      end
      exp_to[s] = 1'b1;
    end else begin
      d = $urandom_range(0, 150);
      repeat (d) tick();
      echo[s] = 1'b1;
      for (int i = 0; i < w; i++) begin
        tick();
        if (noise) echo[1-s] = 1'($urandom);
        if (drop_en && i == w / 2) enable = 1'b0;
        if (dist_valid !== 2'b00) spurious = 1'b1;
      end
      echo = 2'b00;
      if (mode == 0) begin
        n = 0;
        while (dist_valid === 2'b00 && n < 12) begin
          tick();
          n++;
        end
        last_strobe_cyc = cyc;
        model_good(s, w);
        chk("strobe", dist_valid, oh);
        chk("dist_at_strobe", (s == 1) ? dist1 : dist0, exp_dist[s]);
        tick();
        chk("strobe_len", dist_valid, 2'b00);
      end else begin
        exp_dist[s] = 255;
        exp_to[s]   = 1'b1;
      end
    end
    chk("no_spurious_strobe", spurious, 1'b0);
    chk("dist0", dist0, exp_dist[0]);
    chk("dist1", dist1, exp_dist[1]);
    chk("timeout", timeout, {exp_to[1], exp_to[0]});
    exp_sel = 1 - exp_sel;
  endtask

  initial begin
    int n;
    bit busy;
    rst = 1'b0;
    enable = 1'b1;
    echo = 2'b00;
    exp_dist[0] = 0; exp_dist[1] = 0;
    exp_to[0] = 1'b0; exp_to[1] = 1'b0;
    exp_sel = 0;
    last_strobe_cyc = 0;
    repeat (4) tick();
    chk("rst_trig", trig, 2'b00);
    chk("rst_dist0", dist0, 8'd0);
    chk("rst_dist1", dist1, 8'd0);
    chk("rst_valid", dist_valid, 2'b00);
    chk("rst_timeout", timeout, 2'b00);
    rst = 1'b1;
    rel_cyc = cyc;

    serve(0, 200, 1'b0, 1'b0, 1'b0);
    chk("trig_latency", last_trig_cyc - rel_cyc, 1);
    serve(1, 0, 1'b0, 1'b0, 1'b1);
    serve(2, $urandom_range(2020, 2080), 1'b0, 1'b0, 1'b0);
    serve(0, $urandom_range(20, 1900), 1'b0, 1'b0, 1'b0);
    serve(0, 100, 1'b1, 1'b0, 1'b1);
    serve(0, $urandom_range(20, 1900), 1'b1, 1'b0, 1'b1);
    serve(0, $urandom_range(20, 1900), 1'b0, 1'b1, 1'b1);

    busy = 1'b0;
    repeat (P_GAP + 200) begin
      tick();
      if (trig !== 2'b00) busy = 1'b1;
    end
    chk("idle_trig_quiet", busy, 1'b0);
    enable = 1'b1;

    for (int k = 0; k < 6; k++) begin
      serve(0, $urandom_range(20, 1900), k[0], 1'b0, k > 0);
    end

    n = 0;
    while (trig === 2'b00 && n < P_GAP + 50) begin
      tick();
      n++;
    end
    chk("final_trig_seen", trig, (exp_sel == 1) ? 2'b10 : 2'b01);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_trig", trig, 2'b00);
    chk("async_rst_dist0", dist0, 8'd0);
    chk("async_rst_dist1", dist1, 8'd0);
    chk("async_rst_timeout", timeout, 2'b00);
    chk("async_rst_valid", dist_valid, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_scheduler.md
# sensor_scheduler

Time-multiplexing controller for the two ultrasonic paddle sensors (left/right player) in the Pong datapath. It fires one sensor's trigger, times its echo and converts the pulse width to centimetres. It then waits a guard interval before serving the other sensor, so neither sensor hears the other's burst. Per-sensor distances and valid strobes feed the paddle-position logic in the 65 MHz pixel-clock domain.

## Interface
Parameters:
- CYC_PER_TRIG, 650, trigger high time in clk cycles (10 µs at 65 MHz)
- CYC_PER_CM, 3770, echo cycles per centimetre (58 µs at 65 MHz)
- CYC_TIMEOUT, 1_950_000, max cycles in WAIT_RISE or MEASURE (30 ms)
- CYC_GAP, 650_000, guard cycles after each measurement (10 ms)

Ports:
- clk  in  1  65 MHz system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  level; 0 parks the FSM in IDLE after the current measurement completes
- echo  in  2  raw echo inputs, index 0 = left, 1 = right; asynchronous
- trig  out  2  trigger outputs, at most one bit high at any time
- dist0  out  8  left distance, cm, saturating
- dist1  out  8  right distance, cm, saturating
- dist_valid  out  2  one-cycle strobe per sensor when distN updates
- timeout  out  2  sticky per-sensor flag; set on a timeout, cleared on that sensor's next good measurement

## Operation
- Each echo bit passes through a 2-flop synchronizer. All echo logic uses the synchronized value.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, GAP. The `sel` register chooses the sensor being served.
- IDLE: if enable=1, go to TRIG next cycle.
- TRIG: trig[sel]=1 for exactly CYC_PER_TRIG cycles, then go to WAIT_RISE.
- WAIT_RISE: wait for echo[sel] to go high.
  - Rising edge: go to MEASURE.
  - No edge within CYC_TIMEOUT cycles: set timeout[sel], leave distN unchanged, no strobe, go to GAP.
- MEASURE: a sub-counter wraps at CYC_PER_CM-1.
  - Each wrap increments the cm counter, which saturates at 255.
  - Falling edge of echo[sel]: latch cm into dist[sel], pulse dist_valid[sel], clear timeout[sel], go to GAP.
  - CYC_TIMEOUT cycles in MEASURE with no falling edge: set timeout[sel], dist[sel]=255, no strobe, go to GAP.
- GAP: count CYC_GAP cycles, then toggle sel. Go to TRIG if enable=1, otherwise IDLE.
- Echo activity on the non-selected sensor is ignored.
- Sensors are always served alternately, starting with sel=0 after reset.

## Timing
Reset values:
- trig=0, dist0=0, dist1=0, dist_valid=0, timeout=0
- state=IDLE, sel=0, all counters 0

Cycle-level behaviour:
- Rising edge of trig comes 1 cycle after leaving IDLE. Trig is registered.
- Echo-to-state latency is 2 cycles (synchronizer) plus 1 cycle for edge detect.
- dist_valid rises in the same cycle that distN takes its new value.
- Width of the measured pulse W cycles gives cm = min(255, floor(W / CYC_PER_CM)).
- A falling edge in the same cycle as a sub-counter wrap: the wrap counts before the latch.
- A falling edge in the same cycle as the timeout terminal count: the falling edge wins and a valid measurement is reported.
- enable deasserted mid-cycle: the current TRIG/WAIT_RISE/MEASURE/GAP sequence finishes, then the FSM enters IDLE.
- Asynchronous reset mid-measurement: trig drops immediately and all state returns to reset values.

## Configuration
- SENSOR_SCHED_FILTER_EN defined:
  - Each good measurement is averaged with the previous value: distN = (prev + new + 1) >> 1, computed in 9 bits.
  - The first good measurement after reset loads directly.
  - dist_valid timing is unchanged.
- SENSOR_SCHED_FILTER_EN undefined: distN is the raw cm value.

## Structure
- Shared package sensor_pkg:
  - state enum sched_state_t
  - default timing constants at 65 MHz
  - DIST_MAX=255
- Sub-module echo_timer:
  - Holds the cycle sub-counter, the cm counter with saturation, and the timeout comparator.
  - Inputs: start, echo_sync. Outputs: cm, done, timed_out.
  - One instance, shared between both sensors by sel.

## Test plan
Benches override parameters to CYC_PER_TRIG=10, CYC_PER_CM=20, CYC_TIMEOUT=2000, CYC_GAP=100.
- Reset held low, then released with enable=1: trig=00 during reset; trig[0] high exactly 10 cycles, starting 1 cycle after IDLE exits.
- Echo0 pulse of 200 cycles: dist0=10, dist_valid=01 for one cycle; after 100 gap cycles trig[1] fires.
- Echo1 never rises: after 2000 cycles timeout=10, dist1 keeps 0, no strobe; sel returns to 0.
- Echo0 pulse of 6000 cycles: MEASURE times out at 2000, timeout[0]=1, dist0=255; the next 100-cycle pulse gives dist0=5 and clears timeout[0].
- Echo1 toggled while sel=0: no effect on dist1 or strobes. Drop enable during MEASURE: the measurement completes, GAP finishes, FSM holds IDLE with trig=00.
- With SENSOR_SCHED_FILTER_EN: successive pulses of 200 then 400 cycles give dist0=10 then 15.
